// File: rtl/mux_16.sv
// 16:1 bit-picker: Y = X[sel] combinationally, plus a flopped copy Y_q/sel_q captured when en is high.
// Latency: Y 0 cycles, Y_q/sel_q 1 cycle; no backpressure, en=0 simply holds the registers.
// Optional MUX16_CHG_EN adds registered chg, a one-cycle pulse when a capture changes Y_q.
module mux_16 #(
    parameter int N     = 16,
    parameter int SEL_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     X,
    input  logic [SEL_W-1:0] sel,
    input  logic             en,
    output logic             Y,
    output logic             Y_q,
`ifdef MUX16_CHG_EN
    output logic             chg,
`endif
    output logic [SEL_W-1:0] sel_q
);

    logic             y_cap_q;
    logic             y_cap_d;
    logic [SEL_W-1:0] sel_cap_q;
    logic [SEL_W-1:0] sel_cap_d;

    // Every sel code is a legal index, so there is no out-of-range case.
    assign Y = X[sel];

    always_comb begin
        y_cap_d   = y_cap_q;
        sel_cap_d = sel_cap_q;
        if (en) begin
            y_cap_d   = Y;
            sel_cap_d = sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_cap_q   <= 1'b0;
            sel_cap_q <= '0;
        end else begin
            y_cap_q   <= y_cap_d;
            sel_cap_q <= sel_cap_d;
        end
    end

    assign Y_q   = y_cap_q;
    assign sel_q = sel_cap_q;

`ifdef MUX16_CHG_EN
    logic chg_q;
    logic chg_d;

    // Compared against the pre-edge Y_q so the pulse lines up with the new Y_q value.
    always_comb begin
        chg_d = 1'b0;
        if (en) begin
            chg_d = (Y != y_cap_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chg_q <= 1'b0;
        end else begin
            chg_q <= chg_d;
        end
    end

    assign chg = chg_q;
`endif

endmodule

// File: tb/tb_mux_16.sv
// Bench for mux_16: vector table for the combinational path, scoreboard queue for the registered copy.
module tb_mux_16;

    logic        clk;
    logic        rst_n;
    logic [15:0] X;
    logic [3:0]  sel;
    logic        en;
    logic        Y;
    logic        Y_q;
    logic [3:0]  sel_q;
`ifdef MUX16_CHG_EN
    logic        chg;
`endif

    mux_16 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .X     (X),
        .sel   (sel),
        .en    (en),
        .Y     (Y),
        .Y_q   (Y_q),
`ifdef MUX16_CHG_EN
        .chg   (chg),
`endif
        .sel_q (sel_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] x;
        logic [3:0]  s;
        logic        y;
    } vec_t;

    typedef struct packed {
        logic       y;
        logic [3:0] s;
        logic       c;
    } exp_t;

    vec_t vecs[$];
    exp_t sbq[$];

    int tests;
    int fails;

    // Reference model of the registered outputs.
    logic       m_y;
    logic [3:0] m_s;
    logic       m_c;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic bit_of(input logic [15:0] x, input logic [3:0] s);
        logic [15:0] t;
        t = x >> s;
        return t[0];
    endfunction

    // Drive at negedge, check Y right away, push expected registered state, compare after the edge.
    task automatic step(input logic [15:0] x, input logic [3:0] s, input logic e, input logic exp_y);
        exp_t ex;
        exp_t got;
        @(negedge clk);
        X   = x;
        sel = s;
        en  = e;
        #1;
        check("comb_y", 16'(Y), 16'(exp_y));
        if (e) begin
            m_c = (exp_y != m_y);
            m_y = exp_y;
            m_s = s;
        end else begin
            m_c = 1'b0;
        end
        ex = '{y: m_y, s: m_s, c: m_c};
        sbq.push_back(ex);
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            check("sb_empty", 16'd1, 16'd0);
        end else begin
            got = sbq.pop_front();
            check("reg_y_q", 16'(Y_q), 16'(got.y));
            check("reg_sel_q", 16'(sel_q), 16'(got.s));
`ifdef MUX16_CHG_EN
            check("reg_chg", 16'(chg), 16'(got.c));
`endif
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        m_y = 1'b0;
        m_s = 4'h0;
        m_c = 1'b0;
        rst_n = 1'b0;
        X   = 16'h1234;
        sel = 4'd2;
        en  = 1'b1;

        // Reset state, and Y keeps tracking X[sel] while held in reset.
        #3;
        check("rst_y_q", 16'(Y_q), 16'd0);
        check("rst_sel_q", 16'(sel_q), 16'd0);
        check("rst_comb_y", 16'(Y), 16'd1);
        @(posedge clk);
        #1;
        check("rst_no_capture", 16'(Y_q), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fixed vectors, then two full sweeps.
        vecs.push_back('{x: 16'h1234, s: 4'b0001, y: 1'b0});
        vecs.push_back('{x: 16'h1234, s: 4'b0010, y: 1'b1});
        vecs.push_back('{x: 16'h1234, s: 4'b0100, y: 1'b1});
        vecs.push_back('{x: 16'h1234, s: 4'b1000, y: 1'b0});
        for (int i = 0; i < 16; i++)
            vecs.push_back('{x: 16'h1234, s: 4'(i), y: bit_of(16'h1234, 4'(i))});
        for (int i = 0; i < 16; i++)
            vecs.push_back('{x: 16'hA5C3, s: 4'(i), y: bit_of(16'hA5C3, 4'(i))});
        for (int i = 0; i < vecs.size(); i++)
            step(vecs[i].x, vecs[i].s, 1'b1, vecs[i].y);

        // Capture then hold with en=0 over three edges.
        step(16'h0004, 4'd2, 1'b1, 1'b1);
        check("cap_y_q", 16'(Y_q), 16'd1);
        check("cap_sel_q", 16'(sel_q), 16'd2);
        for (int i = 0; i < 3; i++)
            step(16'h0004, 4'd3, 1'b0, 1'b0);
        check("hold_y_q", 16'(Y_q), 16'd1);
        check("hold_sel_q", 16'(sel_q), 16'd2);

        // Mid-cycle changes: Y follows at once, Y_q takes the last value before the edge.
        @(negedge clk);
        en  = 1'b1;
        X   = 16'h8001;
        sel = 4'd0;
        #1;
        check("mid_y_a", 16'(Y), 16'd1);
        #1;
        sel = 4'd7;
        #1;
        check("mid_y_b", 16'(Y), 16'd0);
        X = 16'h0080;
        #1;
        check("mid_y_c", 16'(Y), 16'd1);
        @(posedge clk);
        #1;
        check("mid_y_q", 16'(Y_q), 16'd1);
        check("mid_sel_q", 16'(sel_q), 16'd7);
        m_c = (m_y != 1'b1);
        m_y = 1'b1;
        m_s = 4'd7;
`ifdef MUX16_CHG_EN
        check("mid_chg", 16'(chg), 16'(m_c));
`endif

        // Asynchronous reset mid-cycle with Y_q=1, sel_q=9.
        step(16'h0200, 4'd9, 1'b1, 1'b1);
        check("pre_rst_y_q", 16'(Y_q), 16'd1);
        check("pre_rst_sel_q", 16'(sel_q), 16'd9);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_y_q", 16'(Y_q), 16'd0);
        check("async_sel_q", 16'(sel_q), 16'd0);
        check("async_comb_y", 16'(Y), 16'd1);
        @(posedge clk);
        #1;
        check("rst_en_override", 16'(Y_q), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_y = 1'b0;
        m_s = 4'h0;
        m_c = 1'b0;

        // From Y_q=0, all-ones input: chg pulses once, then stays low while X is stable.
        step(16'hFFFF, 4'd5, 1'b1, 1'b1);
        step(16'hFFFF, 4'd5, 1'b1, 1'b1);
        step(16'hFFFF, 4'd5, 1'b1, 1'b1);
        step(16'h0000, 4'd5, 1'b0, 1'b0);
        step(16'h0000, 4'd5, 1'b1, 1'b0);

        if (sbq.size() != 0)
            check("sb_leftover", 16'(sbq.size()), 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
